// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_SLL  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9
  } aluc_t;

  typedef enum logic [1:0] {A_PC = 2'd0, A_OLDPC = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3} asel_t;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} bsel_t;
  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_t;
  typedef enum logic [1:0] {WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_ALU = 2'd2} wb_t;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_OP, CLS_OPIMM, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_BAD
  } cls_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH     = 4'd0;
  localparam state_t S_DECODE    = 4'd1;
  localparam state_t S_MEMADR    = 4'd2;
  localparam state_t S_MEMRD     = 4'd3;
  localparam state_t S_MEMWB     = 4'd4;
  localparam state_t S_MEMWR     = 4'd5;
  localparam state_t S_EXEC_R    = 4'd6;
  localparam state_t S_EXEC_I    = 4'd7;
  localparam state_t S_EXEC_LUI  = 4'd8;
  localparam state_t S_ALU_WB    = 4'd9;
  localparam state_t S_BRANCH    = 4'd10;
  localparam state_t S_JAL       = 4'd11;
  localparam state_t S_JALR      = 4'd12;
  localparam state_t S_JALR_LINK = 4'd13;
  localparam state_t S_TRAP      = 4'd14;

  // One cycle's worth of datapath control
  typedef struct packed {
    logic  mem_valid;
    logic  mem_we;
    logic  addr_sel;
    logic  ir_we;
    logic  pc_we;
    logic  pc_sel;
    asel_t alu_a_sel;
    bsel_t alu_b_sel;
    imm_t  imm_sel;
    aluc_t aluc;
    logic  rf_we;
    wb_t   wb_sel;
  } ctrl_t;

  // funct3 -> ALU op; alt selects SUB/SRA on the two shared encodings
  function automatic aluc_t f3_aluc(input logic [2:0] f3, input logic alt);
    aluc_t r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request port between the control FSM and the memory system.
interface multicycle_ctrl_if;
  logic mem_valid;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_valid, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_valid, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// Combinational instruction classifier: opcode class, ALU op and legality.
module alu_decoder import riscv_ctrl_pkg::*; (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output cls_t       cls,
  output aluc_t      aluc,
  output logic       illegal
);

  // Classify and pick the ALU op; aluc only matters for OP/OP-IMM/BRANCH
  always_comb begin
    cls     = CLS_BAD;
    aluc    = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        illegal = (funct3 > 3'b010);
      end
      OPC_OP: begin
        cls     = CLS_OP;
        aluc    = f3_aluc(funct3, funct7[5]);
        illegal = !((funct7 == 7'h00) || (funct7 == 7'h20)) ||
                  ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101));
      end
      OPC_OPIMM: begin
        // upper bits are immediate except for shifts; never SUB here
        cls     = CLS_OPIMM;
        aluc    = f3_aluc(funct3, (funct3 == 3'b101) && funct7[5]);
        illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OPC_BRANCH: begin
        cls = CLS_BRANCH;
        case (funct3[2:1])
          2'b00:   aluc = ALU_SUB;
          2'b10:   aluc = ALU_SLT;
          2'b11:   aluc = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL:   cls = CLS_JAL;
      OPC_JALR:  cls = CLS_JALR;
      OPC_LUI:   cls = CLS_LUI;
      OPC_AUIPC: cls = CLS_AUIPC;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM driving datapath strobes, muxes and ALU op.
module multicycle_ctrl import riscv_ctrl_pkg::*; #(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   instr,
  input  logic              zero,
  multicycle_ctrl_if.master mem,
  output logic              ir_we,
  output logic              pc_we,
  output logic              pc_sel,
  output logic [1:0]        alu_a_sel,
  output logic [1:0]        alu_b_sel,
  output logic [2:0]        imm_sel,
  output logic [3:0]        aluc,
  output logic              rf_we,
  output logic [1:0]        wb_sel,
  output logic              illegal,
  output logic [3:0]        state_dbg
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctl;
  cls_t   cls;
  aluc_t  dec_aluc;
  logic   dec_illegal;

  // register fields are consumed by the datapath, not here
  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  alu_decoder u_dec (
    .opcode  (instr[6:0]),
    .funct3  (instr[14:12]),
    .funct7  (instr[31:25]),
    .cls     (cls),
    .aluc    (dec_aluc),
    .illegal (dec_illegal)
  );

  // Next state and per-state control word; idle word is all zero (aluc=ADD)
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    ctl       = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_valid = 1'b1;
        if (mem.mem_ready) begin
          ctl.ir_we     = 1'b1;
          ctl.alu_b_sel = B_FOUR;
          ctl.pc_we     = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOUT captures OLDPC+imm for branch/jal/auipc
        ctl.alu_a_sel = A_OLDPC;
        ctl.alu_b_sel = B_IMM;
        case (cls)
          CLS_STORE:          ctl.imm_sel = IMM_S;
          CLS_BRANCH:         ctl.imm_sel = IMM_B;
          CLS_LUI, CLS_AUIPC: ctl.imm_sel = IMM_U;
          CLS_JAL:            ctl.imm_sel = IMM_J;
          default:            ctl.imm_sel = IMM_I;
        endcase
        if (dec_illegal) begin
          if (ILLEGAL_TRAP) begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
            CLS_OP:              state_d = S_EXEC_R;
            CLS_OPIMM:           state_d = S_EXEC_I;
            CLS_BRANCH:          state_d = S_BRANCH;
            CLS_JAL:             state_d = S_JAL;
            CLS_JALR:            state_d = S_JALR;
            CLS_LUI:             state_d = S_EXEC_LUI;
            CLS_AUIPC:           state_d = S_ALU_WB;
            default:             state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        ctl.alu_a_sel = A_RS1;
        ctl.alu_b_sel = B_IMM;
        ctl.imm_sel   = (cls == CLS_STORE) ? IMM_S : IMM_I;
        state_d       = (cls == CLS_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_valid = 1'b1;
        ctl.addr_sel  = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.rf_we  = 1'b1;
        ctl.wb_sel = WB_MDR;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_valid = 1'b1;
        ctl.mem_we    = 1'b1;
        ctl.addr_sel  = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ctl.alu_a_sel = A_RS1;
        ctl.alu_b_sel = B_RS2;
        ctl.aluc      = dec_aluc;
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctl.alu_a_sel = A_RS1;
        ctl.alu_b_sel = B_IMM;
        ctl.aluc      = dec_aluc;
        state_d       = S_ALU_WB;
      end
      S_EXEC_LUI: begin
        ctl.alu_a_sel = A_ZERO;
        ctl.alu_b_sel = B_IMM;
        ctl.imm_sel   = IMM_U;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl.rf_we = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0]^funct3[2] marks the "taken when nonzero" conditions
        ctl.alu_a_sel = A_RS1;
        ctl.alu_b_sel = B_RS2;
        ctl.aluc      = dec_aluc;
        ctl.pc_we     = zero ^ (instr[12] ^ instr[14]);
        ctl.pc_sel    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL, S_JALR_LINK: begin
        ctl.alu_a_sel = A_OLDPC;
        ctl.alu_b_sel = B_FOUR;
        ctl.rf_we     = 1'b1;
        ctl.wb_sel    = WB_ALU;
        ctl.pc_we     = 1'b1;
        ctl.pc_sel    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JALR: begin
        ctl.alu_a_sel = A_RS1;
        ctl.alu_b_sel = B_IMM;
        state_d       = S_JALR_LINK;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // reset kills any in-flight request or strobe without waiting for a clock
    if (!rst_n) ctl = '0;
  end

  // State and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem.mem_valid = ctl.mem_valid;
  assign mem.mem_we    = ctl.mem_we;
  assign mem.addr_sel  = ctl.addr_sel;
  assign ir_we         = ctl.ir_we;
  assign pc_we         = ctl.pc_we;
  assign pc_sel        = ctl.pc_sel;
  assign alu_a_sel     = ctl.alu_a_sel;
  assign alu_b_sel     = ctl.alu_b_sel;
  assign imm_sel       = ctl.imm_sel;
  assign aluc          = ctl.aluc;
  assign rf_we         = ctl.rf_we;
  assign wb_sel        = ctl.wb_sel;
  assign illegal       = illegal_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level sequence model.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic        clk, rst_n, zero;
  logic [31:0] instr;
  logic        ir_we, pc_we, pc_sel, rf_we, illegal;
  logic [1:0]  alu_a_sel, alu_b_sel, wb_sel;
  logic [2:0]  imm_sel;
  logic [3:0]  aluc, state_dbg;
  int          n_vec, n_err;

  multicycle_ctrl_if mem();

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem(mem),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .imm_sel(imm_sel), .aluc(aluc), .rf_we(rf_we),
    .wb_sel(wb_sel), .illegal(illegal), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected control word
  typedef struct packed {
    logic       mv, mwe, asl, irw, pcw, pcs;
    logic [1:0] a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       rfw;
    logic [1:0] wb;
    logic       ill;
  } sig_t;

  function automatic sig_t obs();
    sig_t s;
    s.mv = mem.mem_valid; s.mwe = mem.mem_we; s.asl = mem.addr_sel;
    s.irw = ir_we; s.pcw = pc_we; s.pcs = pc_sel;
    s.a = alu_a_sel; s.b = alu_b_sel; s.imm = imm_sel; s.alu = aluc;
    s.rfw = rf_we; s.wb = wb_sel; s.ill = illegal;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, leave 1 time unit for settling
  task automatic cyc(input logic r, input logic z);
    @(negedge clk);
    mem.mem_ready = r;
    zero          = z;
    #1;
  endtask

  // Reference: ALU op named by the instruction
  function automatic logic [3:0] exp_aluc(input logic [31:0] ins);
    logic [3:0] base [8];
    logic [2:0] f3;
    base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    f3 = ins[14:12];
    case (ins[6:0])
      7'h33: begin
        if (ins[30] && f3 == 3'd0) return 4'd1;
        if (ins[30] && f3 == 3'd5) return 4'd7;
        return base[f3];
      end
      7'h13: return (ins[30] && f3 == 3'd5) ? 4'd7 : base[f3];
      7'h63: return f3[2] ? (f3[1] ? 4'd9 : 4'd8) : 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'd0: return z;    // BEQ
      3'd1: return !z;   // BNE
      3'd4: return !z;   // BLT: slt=1 -> nonzero
      3'd5: return z;    // BGE
      3'd6: return !z;   // BLTU
      default: return z; // BGEU
    endcase
  endfunction

  function automatic logic [2:0] dec_imm(input logic [6:0] op);
    case (op)
      7'h23: return 3'd1;
      7'h63: return 3'd2;
      7'h37, 7'h17: return 3'd3;
      7'h6F: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    r  = $urandom;
    f3 = 3'($urandom);
    case ($urandom_range(0, 8))
      0: begin
        while (f3 == 3'd3 || f3 >= 3'd6) f3 = 3'($urandom);
        return {r[31:15], f3, r[11:7], 7'h03};
      end
      1: return {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'h23};
      2: return {1'b0, r[30] & (f3 == 3'd0 || f3 == 3'd5), 5'b0, r[24:15], f3, r[11:7], 7'h33};
      3: begin
        if (f3 == 3'd1) return {7'b0, r[24:15], f3, r[11:7], 7'h13};
        if (f3 == 3'd5) return {1'b0, r[30], 5'b0, r[24:15], f3, r[11:7], 7'h13};
        return {r[31:15], f3, r[11:7], 7'h13};
      end
      4: begin
        while (f3 == 3'd2 || f3 == 3'd3) f3 = 3'($urandom);
        return {r[31:15], f3, r[11:7], 7'h63};
      end
      5: return {r[31:7], 7'h6F};
      6: return {r[31:15], 3'b0, r[11:7], 7'h67};
      7: return {r[31:7], 7'h37};
      default: return {r[31:7], 7'h17};
    endcase
  endfunction

  // Walk one instruction from FETCH to its last state, checking every cycle.
  // fw/mw: memory wait cycles; zm: branch zero 0/1 forced, 2 random; bad: stop after DECODE
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int zm, input bit bad);
    sig_t e;
    logic z;
    logic [6:0] op;
    op = ins[6:0];
    for (int i = 0; i <= fw; i++) begin
      cyc(i == fw, 1'($urandom));
      e = '0; e.mv = 1'b1;
      if (i == fw) begin e.irw = 1'b1; e.b = 2'd2; e.pcw = 1'b1; end
      chk("fetch", 32'(obs()), 32'(e));
    end
    instr = ins;
    cyc(1'($urandom), 1'($urandom));
    e = '0; e.a = 2'd1; e.b = 2'd1; e.imm = dec_imm(op);
    chk("decode", 32'(obs()), 32'(e));
    if (bad) return;
    case (op)
      7'h03, 7'h23: begin
        cyc(1'($urandom), 1'($urandom));
        e = '0; e.a = 2'd2; e.b = 2'd1; e.imm = (op == 7'h23) ? 3'd1 : 3'd0;
        chk("memadr", 32'(obs()), 32'(e));
        for (int i = 0; i <= mw; i++) begin
          cyc(i == mw, 1'($urandom));
          e = '0; e.mv = 1'b1; e.asl = 1'b1; e.mwe = (op == 7'h23);
          chk(op == 7'h23 ? "memwr" : "memrd", 32'(obs()), 32'(e));
        end
        if (op == 7'h03) begin
          cyc(1'($urandom), 1'($urandom));
          e = '0; e.rfw = 1'b1; e.wb = 2'd1;
          chk("memwb", 32'(obs()), 32'(e));
        end
      end
      7'h33, 7'h13, 7'h37, 7'h17: begin
        if (op != 7'h17) begin
          cyc(1'($urandom), 1'($urandom));
          e = '0;
          e.a   = (op == 7'h37) ? 2'd3 : 2'd2;
          e.b   = (op == 7'h33) ? 2'd0 : 2'd1;
          e.imm = (op == 7'h37) ? 3'd3 : 3'd0;
          e.alu = exp_aluc(ins);
          chk("exec", 32'(obs()), 32'(e));
        end
        cyc(1'($urandom), 1'($urandom));
        e = '0; e.rfw = 1'b1;
        chk("alu_wb", 32'(obs()), 32'(e));
      end
      7'h63: begin
        z = (zm == 2) ? 1'($urandom) : zm[0];
        cyc(1'($urandom), z);
        e = '0; e.a = 2'd2; e.alu = exp_aluc(ins);
        e.pcw = branch_taken(ins[14:12], z); e.pcs = 1'b1;
        chk("branch", 32'(obs()), 32'(e));
      end
      default: begin // JAL, JALR
        if (op == 7'h67) begin
          cyc(1'($urandom), 1'($urandom));
          e = '0; e.a = 2'd2; e.b = 2'd1;
          chk("jalr", 32'(obs()), 32'(e));
        end
        cyc(1'($urandom), 1'($urandom));
        e = '0; e.a = 2'd1; e.b = 2'd2; e.rfw = 1'b1; e.wb = 2'd2; e.pcw = 1'b1; e.pcs = 1'b1;
        chk("link", 32'(obs()), 32'(e));
      end
    endcase
  endtask

  logic [31:0] bad_tab [7];

  initial begin
    sig_t e;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; zero = 1'b0; instr = 32'h0; mem.mem_ready = 1'b0;
    bad_tab = '{32'h0000007F, 32'h0020A463, 32'h022081B3, 32'h4020C1B3,
                32'h40209193, 32'h0000B183, 32'h0020B023};

    // reset state: everything quiet, even the fetch request
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sig", 32'(obs()), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(S_FETCH));
    @(negedge clk); rst_n = 1'b1; #1;
    e = '0; e.mv = 1'b1;
    chk("rel_fetch", 32'(obs()), 32'(e));

    // directed cases
    run_instr(32'h002081B3, 3, 0, 2, 1'b0); // ADD, 4-cycle fetch overall
    run_instr(32'h402081B3, 0, 0, 2, 1'b0); // SUB
    run_instr(32'h4020D193, 1, 0, 2, 1'b0); // SRAI
    run_instr(32'h0020C463, 0, 0, 0, 1'b0); // BLT, zero=0 -> taken
    run_instr(32'h0020C463, 0, 0, 1, 1'b0); // BLT, zero=1 -> not taken
    run_instr(32'h0000A183, 0, 2, 2, 1'b0); // LW, ready 2 late
    run_instr(32'h0020A023, 0, 1, 2, 1'b0); // SW
    run_instr(32'h000080E7, 0, 0, 2, 1'b0); // JALR

    // reset in the middle of a load request
    cyc(1'b1, 1'b0);
    e = '0; e.mv = 1'b1; e.irw = 1'b1; e.b = 2'd2; e.pcw = 1'b1;
    chk("rm_fetch", 32'(obs()), 32'(e));
    instr = 32'h0000A183;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    e = '0; e.mv = 1'b1; e.asl = 1'b1;
    chk("rm_memrd", 32'(obs()), 32'(e));
    rst_n = 1'b0; #1;
    chk("rm_rst_sig", 32'(obs()), 32'h0);
    chk("rm_rst_state", 32'(state_dbg), 32'(S_FETCH));
    cyc(1'b1, 1'b0);
    chk("rm_hold", 32'(obs()), 32'h0);
    @(negedge clk); rst_n = 1'b1; mem.mem_ready = 1'b0; #1;
    e = '0; e.mv = 1'b1;
    chk("rm_release", 32'(obs()), 32'(e));

    // random legal stream
    for (int n = 0; n < 150; n++)
      run_instr(rnd_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 2, 1'b0);

    // illegal encodings: trap, stay trapped, clear only by reset
    for (int k = 0; k < 7; k++) begin
      run_instr(bad_tab[k], $urandom_range(0, 2), 0, 2, 1'b1);
      for (int i = 0; i < ((k == 0) ? 20 : 3); i++) begin
        cyc(1'($urandom), 1'($urandom));
        e = '0; e.ill = 1'b1;
        chk("trap", 32'(obs()), 32'(e));
      end
      chk("trap_state", 32'(state_dbg), 32'(S_TRAP));
      rst_n = 1'b0; #1;
      chk("trap_clear", 32'(obs()), 32'h0);
      @(negedge clk); rst_n = 1'b1; mem.mem_ready = 1'b0; #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
